// File: rtl/isp_filter_ctrl_pkg.sv
// isp_pkg: filter encodings, index mapping and controller state type shared by the ISP filter controller.
package isp_pkg;
  localparam logic [7:0] BYPASS        = 8'h00;
  localparam logic [7:0] RED_FILTER    = 8'h01;
  localparam logic [7:0] GREEN_FILTER  = 8'h02;
  localparam logic [7:0] BLUE_FILTER   = 8'h04;
  localparam logic [7:0] GRAY_FILTER   = 8'h08;
  localparam logic [7:0] INVERT_FILTER = 8'h10;
  localparam logic [7:0] SEPIA_FILTER  = 8'h20;
  localparam logic [7:0] GAUSS_FILTER  = 8'h40;
  localparam logic [7:0] SOBEL_FILTER  = 8'h80;
  localparam int NUM_FILTERS = 9;
  typedef enum logic [1:0] {IDLE, PENDING, WARMUP} ctrl_state_e;
  function automatic logic [7:0] idx_to_onehot(input logic [3:0] idx);
    return idx == 4'd0 ? BYPASS : 8'd1 << (idx - 4'd1);
  endfunction
  function automatic logic is_windowed(input logic [7:0] f);
    return f == GAUSS_FILTER || f == SOBEL_FILTER;
  endfunction
endpackage

// File: rtl/isp_filter_ctrl_btn_debounce.sv
// btn_debounce: 2-FF synchronizer, stability counter and one-cycle press pulse on an accepted rising level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic s1, s2, level;
  logic [CW-1:0] cnt;
  logic done;
  assign done = cnt == CW'(DEBOUNCE_CYCLES - 1) && s2 != level;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      level <= 1'b0;
      cnt <= '0;
      press <= 1'b0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      cnt <= (s2 == level || done) ? '0 : cnt + 1'b1;
      level <= done ? s2 : level;
      press <= done && s2;
    end
  end
endmodule

// File: rtl/isp_filter_ctrl.sv
// isp_filter_ctrl: button-driven one-hot filter select committed at frame boundaries, with line-buffer warm-up blanking.
// Optional ISP_FILTER_AUTOCYCLE_EN adds auto_en, stepping the filter every AUTO_FRAMES frames while idle.
module isp_filter_ctrl
  import isp_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int WARMUP_LINES = 2
`ifdef ISP_FILTER_AUTOCYCLE_EN
  , parameter int AUTO_FRAMES = 120
`endif
) (
  input  logic clk,
  input  logic reset,
`ifdef ISP_FILTER_AUTOCYCLE_EN
  input  logic auto_en,
`endif
  input  logic btn_next,
  input  logic btn_prev,
  input  logic frame_start,
  input  logic line_start,
  output logic [7:0] filter_sel,
  output logic blank,
  output logic busy
);
  localparam int LW = $clog2(WARMUP_LINES + 1);
  localparam logic [3:0] LAST = 4'(NUM_FILTERS - 1);
  logic p_next, p_prev, nxt, prv, line_last;
  logic [3:0] req_idx, cur_idx, req_nx;
  logic [LW-1:0] line_cnt;
  ctrl_state_e state;
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (.clk(clk), .reset(reset), .btn(btn_next), .press(p_next));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev (.clk(clk), .reset(reset), .btn(btn_prev), .press(p_prev));
`ifdef ISP_FILTER_AUTOCYCLE_EN
  localparam int FW = $clog2(AUTO_FRAMES + 1);
  logic [FW-1:0] frame_cnt;
  logic auto_next;
  assign auto_next = auto_en && state == IDLE && frame_start && frame_cnt == FW'(AUTO_FRAMES - 1);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) frame_cnt <= '0;
    else if (p_next || p_prev || !auto_en || auto_next) frame_cnt <= '0;
    else if (state == IDLE && frame_start) frame_cnt <= frame_cnt + 1'b1;
  end
  assign nxt = (p_next || auto_next) && !p_prev;
`else
  assign nxt = p_next && !p_prev;
`endif
  // Simultaneous presses cancel each other.
  assign prv = p_prev && !p_next;
  assign line_last = line_cnt == LW'(WARMUP_LINES - 1);
  always_comb req_nx = nxt ? (req_idx == LAST ? 4'd0 : req_idx + 4'd1) :
                       prv ? (req_idx == 4'd0 ? LAST : req_idx - 4'd1) : req_idx;
  assign busy = state != IDLE;
  assign blank = state == WARMUP;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      req_idx <= 4'd0;
      cur_idx <= 4'd0;
      line_cnt <= '0;
      filter_sel <= BYPASS;
    end else begin
      req_idx <= req_nx;
      case (state)
        IDLE: if (nxt || prv) state <= PENDING;
        PENDING: if (frame_start) begin
          cur_idx <= req_idx;
          filter_sel <= idx_to_onehot(req_idx);
          // A press landing on the commit edge stays queued for the next frame.
          state <= is_windowed(idx_to_onehot(req_idx)) ? WARMUP : (nxt || prv) ? PENDING : IDLE;
        end
        WARMUP: if (line_start) begin
          line_cnt <= line_last ? '0 : line_cnt + 1'b1;
          if (line_last) state <= req_nx == cur_idx ? IDLE : PENDING;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/isp_filter_ctrl.md
# isp_filter_ctrl

Sequencer for the ISP filter datapath. It converts two push-buttons into a one-hot filter selection and commits each change only at a frame boundary, so a frame is never rendered with two filters. After switching to a line-buffered filter (Gaussian or Sobel), it blanks the output for a fixed number of lines while the line buffers refill. It sits between the board buttons / VGA timing generator and the ISP `filter_sel` input.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000: cycles a synchronized button level must stay stable before it is accepted.
- `WARMUP_LINES`, default 2: `line_start` pulses during which output is blanked after a windowed filter is committed.
- `AUTO_FRAMES`, default 120: frames per step in auto-cycle mode (only with the macro in Configuration).

Ports:
- `clk`  in  1  pixel-domain clock; single clock domain.
- `reset`  in  1  asynchronous, active-low reset.
- `btn_next`  in  1  raw button; press = advance the filter.
- `btn_prev`  in  1  raw button; press = step the filter back.
- `frame_start`  in  1  one-cycle pulse at the start of vertical blanking.
- `line_start`  in  1  one-cycle pulse at the start of each active line.
- `filter_sel`  out  8  committed one-hot filter; 8'h00 = bypass.
- `blank`  out  1  high = downstream forces pixel output to 12'h000.
- `busy`  out  1  high while a change is pending or warm-up is running.

## Operation
- Filter order, index 0..8: 8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80.
- `next` from index 8 wraps to 0. `prev` from index 0 wraps to 8.
- Windowed filters: 8'h40 (Gaussian) and 8'h80 (Sobel).
- Per-button debounce:
  - 2-FF synchronizer feeds a stability counter that resets on any level change.
  - The accepted level updates when the counter reaches `DEBOUNCE_CYCLES`-1.
  - A 0→1 change of the accepted level emits one press pulse.
- `req_idx` register, 4 bits:
  - `next` press → `req_idx`+1, wrapping.
  - `prev` press → `req_idx`-1, wrapping.
  - Both presses in the same cycle → both ignored.
- FSM, 2-bit state:
  - IDLE: `req_idx` = `cur_idx`. Any press → PENDING.
  - PENDING: on `frame_start`, `cur_idx` ← `req_idx`. If the new filter is windowed → WARMUP, else → IDLE. Further presses keep updating `req_idx` and the state stays PENDING.
  - WARMUP: counts `line_start` pulses. After the `WARMUP_LINES`-th pulse → IDLE if `req_idx` = `cur_idx`, else → PENDING.
- Presses during WARMUP update `req_idx` only; `cur_idx` does not change until warm-up completes and a later `frame_start` arrives.
- `busy` = (state ≠ IDLE).
- `blank` = (state = WARMUP).
- A press that walks `req_idx` back to `cur_idx` before `frame_start` still commits; it is a no-op change and does not trigger warm-up unless the filter is windowed.

## Timing
- During reset: `filter_sel` = 8'h00, `blank` = 0, `busy` = 0, state IDLE, all counters 0, accepted button levels 0.
- Reset asserted mid-operation aborts immediately to these values.
- Press pulse: 2 cycles of sync + `DEBOUNCE_CYCLES` after the raw edge, ±1 cycle.
- `req_idx` updates the cycle after the press pulse. `busy` rises the same cycle.
- `filter_sel`, `blank`, and state are registered and change the cycle after `frame_start` is sampled.
- A press pulse and `frame_start` in the same cycle while IDLE: the request is registered and commits at the *next* `frame_start`.
- A press pulse and `frame_start` in the same cycle while PENDING: the old `req_idx` commits, and the new request stays pending.
- `blank` falls the cycle after the `WARMUP_LINES`-th `line_start`.
- `frame_start` during WARMUP does not commit anything.

## Configuration
- Macro `ISP_FILTER_AUTOCYCLE_EN`.
- Defined:
  - Adds input `auto_en` (1 bit).
  - While `auto_en`=1 and state is IDLE, an internal frame counter produces a `next` request every `AUTO_FRAMES` `frame_start` pulses.
  - Button presses still act and reset the frame counter.
- Undefined: the port, counter, and `AUTO_FRAMES` logic are absent; behaviour is buttons only.

## Structure
- Package `isp_pkg` holds:
  - The one-hot filter constants (`RED_FILTER` … `SOBEL_FILTER`, plus `BYPASS` = 8'h00).
  - `NUM_FILTERS` = 9.
  - The index→one-hot function.
  - The FSM state enum `ctrl_state_e` {IDLE, PENDING, WARMUP}.
  - `is_windowed()`.
- Sub-module `btn_debounce` (synchronizer + stability counter + rising-edge pulse), instantiated twice.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `WARMUP_LINES`=2.
- Reset released with no stimulus → `filter_sel`=8'h00, `blank`=0, `busy`=0 for 1000 cycles.
- `btn_next` held for 10 cycles, then `frame_start` → `busy` rises about 7 cycles after the edge; `filter_sel`=8'h01 the cycle after `frame_start`; `busy` falls.
- Button bouncing 1-0-1-0 at 2-cycle intervals, then stable high → exactly one press; `req_idx`=1.
- 7 `next` presses, then `frame_start` → `filter_sel`=8'h40 and `blank`=1. `blank` stays high through the first `line_start` and falls the cycle after the second.
- `prev` from reset, then `frame_start` → `filter_sel`=8'h80 (wrap).
- `btn_next` and `btn_prev` pulses in the same cycle → `req_idx` unchanged and `busy` stays 0.
- Press pulse coinciding with `frame_start` while IDLE → no change on that frame; commits at the next `frame_start`.
